// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and receiver state encoding
package uart_pkg;

   // Frame shape shared with the transmitter
   localparam int DATA_BITS = 8;
   localparam int CNT_W     = 16;
   localparam int IDX_W     = 3;

   // Receiver states, 3-bit encoding; codes 5..7 are unused and recover to IDLE
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;

   // Start-bit confirmation point: mid-bit, rounded down
   function automatic logic [CNT_W-1:0] half_bit(input logic [CNT_W-1:0] clks_per_bit);
      return (clks_per_bit - CNT_W'(1)) >> 1;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the asynchronous serial line
module uart_rx_sync (
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic i_Async,
   output logic o_Sync
);

   logic meta;
   logic sync;

   // Two back-to-back flops; both reset to the idle (high) line level
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         meta <= 1'b1;
         sync <= 1'b1;
      end else begin
         meta <= i_Async;
         sync <= meta;
      end
   end

   assign o_Sync = sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with framing-error and glitch handling
module uart_rx
   import uart_pkg::*;
#(
   parameter logic [CNT_W-1:0] CLKS_PER_BIT = 16'd100
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic                 i_Rx_Serial,
   output logic                 o_Rx_DV,
   output logic [DATA_BITS-1:0] o_Rx_Byte,
   output logic                 o_Rx_Active,
   output logic                 o_Frame_Err
);

   localparam logic [CNT_W-1:0] HALF     = half_bit(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST     = CLKS_PER_BIT - CNT_W'(1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   logic                 rx_s;

   rx_state_t            state,    state_n;
   logic [CNT_W-1:0]     cnt,      cnt_n;
   logic [IDX_W-1:0]     idx,      idx_n;
   logic [DATA_BITS-1:0] shift,    shift_n;
   logic [DATA_BITS-1:0] rx_byte,  rx_byte_n;
   logic                 rx_dv,    rx_dv_n;
   logic                 frame_err, frame_err_n;

   uart_rx_sync u_sync (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .i_Async (i_Rx_Serial),
      .o_Sync  (rx_s)
   );

   // State, counters, assembled data and output strobes
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shift     <= '0;
         rx_byte   <= '0;
         rx_dv     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         shift     <= shift_n;
         rx_byte   <= rx_byte_n;
         rx_dv     <= rx_dv_n;
         frame_err <= frame_err_n;
      end
   end

   // Frame sequencing: confirm start mid-bit, then sample each bit one period later
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      idx_n       = idx;
      shift_n     = shift;
      rx_byte_n   = rx_byte;
      rx_dv_n     = 1'b0;
      frame_err_n = 1'b0;

      case (state)
         IDLE: begin
            cnt_n = '0;
            idx_n = '0;
            if (!rx_s) begin
               state_n = START;
            end
         end

         START: begin
            if (cnt == HALF) begin
               cnt_n = '0;
               // A start that has gone high again by mid-bit was a glitch
               state_n = rx_s ? IDLE : DATA;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end

         DATA: begin
            if (cnt == LAST) begin
               cnt_n        = '0;
               shift_n[idx] = rx_s;
               if (idx == LAST_IDX) begin
                  idx_n   = '0;
                  state_n = STOP;
               end else begin
                  idx_n = idx + IDX_W'(1);
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end

         STOP: begin
            if (cnt == LAST) begin
               cnt_n = '0;
               // Return straight to IDLE at mid stop bit so a following start is not missed
               if (rx_s) begin
                  rx_byte_n = shift;
                  rx_dv_n   = 1'b1;
                  state_n   = IDLE;
               end else begin
                  frame_err_n = 1'b1;
                  state_n     = BREAK;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end

         BREAK: begin
            // A line held low must return high before a new frame can start
            cnt_n = '0;
            idx_n = '0;
            if (rx_s) begin
               state_n = IDLE;
            end
         end

         default: begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = '0;
         end
      endcase
   end

   assign o_Rx_DV     = rx_dv;
   assign o_Rx_Byte   = rx_byte;
   assign o_Frame_Err = frame_err;
   assign o_Rx_Active = (state == START) || (state == DATA) || (state == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at 8 and 100 clocks per bit
module tb_uart_rx;

   logic       i_Clock = 1'b0;
   logic       rst8 = 1'b1, rst100 = 1'b1;
   logic       rx8 = 1'b1,  rx100 = 1'b1;
   logic       dv8, act8, ferr8, dv100, act100, ferr100;
   logic [7:0] byte8, byte100;

   always #5 i_Clock = ~i_Clock;

   uart_rx #(.CLKS_PER_BIT(16'd8)) u_dut8 (
      .i_Clock     (i_Clock),
      .i_Reset     (rst8),
      .i_Rx_Serial (rx8),
      .o_Rx_DV     (dv8),
      .o_Rx_Byte   (byte8),
      .o_Rx_Active (act8),
      .o_Frame_Err (ferr8)
   );

   uart_rx #(.CLKS_PER_BIT(16'd100)) u_dut100 (
      .i_Clock     (i_Clock),
      .i_Reset     (rst100),
      .i_Rx_Serial (rx100),
      .o_Rx_DV     (dv100),
      .o_Rx_Byte   (byte100),
      .o_Rx_Active (act100),
      .o_Frame_Err (ferr100)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] q8[$];
   logic [7:0] q100[$];

   int   last_dv_cyc8 = 0, prev_dv_cyc8 = 0;
   int   ferr_cnt8 = 0, ferr_cnt100 = 0;
   int   rx_cnt100 = 0;
   int   seen3c = 0, byte_glitch8 = 0;
   logic prev_dv8 = 1'b0, prev_ferr8 = 1'b0, prev_dv100 = 1'b0;
   logic [7:0] prev_byte8 = 8'h00;
   logic rst_seen8 = 1'b1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(posedge i_Clock) begin
      cyc       <= cyc + 1;
      rst_seen8 <= rst8;
   end

   // Scoreboard and strobe-shape monitor for the 8-clock receiver
   always @(negedge i_Clock) begin
      logic [7:0] exp_b;
      if (dv8) begin
         check("dv8_width", {31'd0, prev_dv8}, 0);
         check("dv8_ferr_excl", {31'd0, ferr8}, 0);
         if (q8.size() == 0) begin
            check("dv8_unexpected", q8.size(), 1);
         end else begin
            exp_b = q8.pop_front();
            check("rx8_byte", {24'd0, byte8}, {24'd0, exp_b});
         end
         prev_dv_cyc8 = last_dv_cyc8;
         last_dv_cyc8 = cyc;
      end
      if (ferr8) begin
         ferr_cnt8++;
         check("ferr8_width", {31'd0, prev_ferr8}, 0);
      end
      if (!rst_seen8 && !dv8 && byte8 !== prev_byte8) byte_glitch8++;
      if (byte8 == 8'h3C) seen3c++;
      prev_dv8   = dv8;
      prev_ferr8 = ferr8;
      prev_byte8 = byte8;
   end

   // Scoreboard for the 100-clock receiver
   always @(negedge i_Clock) begin
      logic [7:0] exp_b;
      if (dv100) begin
         check("dv100_width", {31'd0, prev_dv100}, 0);
         rx_cnt100++;
         if (q100.size() == 0) begin
            check("dv100_unexpected", q100.size(), 1);
         end else begin
            exp_b = q100.pop_front();
            check("rx100_byte", {24'd0, byte100}, {24'd0, exp_b});
         end
      end
      if (ferr100) ferr_cnt100++;
      prev_dv100 = dv100;
   end

   task automatic drive(input bit sel, input logic v);
      if (sel) rx100 = v;
      else     rx8   = v;
   endtask

   // Drives one full frame; call right after a falling clock edge
   task automatic send_frame(input bit sel, input logic [7:0] data, input int per,
                             input logic stop_val, output int t0);
      drive(sel, 1'b0);
      t0 = cyc + 1;
      repeat (per) @(negedge i_Clock);
      for (int k = 0; k < 8; k++) begin
         drive(sel, data[k]);
         repeat (per) @(negedge i_Clock);
      end
      drive(sel, stop_val);
      repeat (per) @(negedge i_Clock);
   endtask

   task automatic wait_drain(input bit sel, input int budget);
      int n;
      n = sel ? q100.size() : q8.size();
      for (int i = 0; i < budget && n != 0; i++) begin
         @(negedge i_Clock);
         n = sel ? q100.size() : q8.size();
      end
      check(sel ? "drain100" : "drain8", n, 0);
   endtask

   initial begin
      int t0, t_a, seen, ferr_before;
      logic [7:0] b;

      repeat (4) @(negedge i_Clock);
      rst8   = 1'b0;
      rst100 = 1'b0;
      @(negedge i_Clock);
      check("rst8_dv",    {31'd0, dv8},    0);
      check("rst8_byte",  {24'd0, byte8},  0);
      check("rst8_act",   {31'd0, act8},   0);
      check("rst8_ferr",  {31'd0, ferr8},  0);
      check("rst100_dv",  {31'd0, dv100},  0);
      check("rst100_byte",{24'd0, byte100},0);
      check("rst100_act", {31'd0, act100}, 0);
      repeat (5) @(negedge i_Clock);

      // Ideal 0xA5 with latency check
      q8.push_back(8'hA5);
      send_frame(1'b0, 8'hA5, 8, 1'b1, t0);
      wait_drain(1'b0, 50);
      check("a5_latency", last_dv_cyc8 - t0, 78);
      check("a5_ferr", ferr_cnt8, 0);
      repeat (10) @(negedge i_Clock);

      // Back-to-back frames, one stop bit each
      q8.push_back(8'h00);
      q8.push_back(8'hFF);
      send_frame(1'b0, 8'h00, 8, 1'b1, t_a);
      send_frame(1'b0, 8'hFF, 8, 1'b1, t0);
      wait_drain(1'b0, 50);
      check("b2b_spacing", last_dv_cyc8 - prev_dv_cyc8, 80);
      check("b2b_byte", {24'd0, byte8}, 32'hFF);
      repeat (10) @(negedge i_Clock);

      // Two-cycle start glitch
      seen = 0;
      drive(1'b0, 1'b0);
      for (int i = 0; i < 24; i++) begin
         @(negedge i_Clock);
         if (i == 1) drive(1'b0, 1'b1);
         if (act8) seen++;
      end
      check("glitch_active_cycles", seen, 4);
      check("glitch_ferr", ferr_cnt8, 0);
      check("glitch_byte", {24'd0, byte8}, 32'hFF);

      // Framing error followed by a held-low line, then a good frame
      send_frame(1'b0, 8'h3C, 8, 1'b0, t0);
      seen = 0;
      for (int i = 0; i < 32; i++) begin
         @(negedge i_Clock);
         if (act8) seen++;
      end
      check("ferr_count", ferr_cnt8, 1);
      check("break_no_retrigger", seen, 0);
      check("ferr_byte_kept", {24'd0, byte8}, 32'hFF);
      drive(1'b0, 1'b1);
      repeat (16) @(negedge i_Clock);
      q8.push_back(8'h12);
      send_frame(1'b0, 8'h12, 8, 1'b1, t0);
      wait_drain(1'b0, 50);
      repeat (10) @(negedge i_Clock);

      // Reset during data bit 4 of 0x77
      b = 8'h77;
      drive(1'b0, 1'b0);
      repeat (8) @(negedge i_Clock);
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, b[k]);
         repeat (8) @(negedge i_Clock);
      end
      drive(1'b0, b[4]);
      repeat (3) @(negedge i_Clock);
      check("pre_rst_active", {31'd0, act8}, 1);
      ferr_before = ferr_cnt8;
      rst8 = 1'b1;
      @(negedge i_Clock);
      rst8 = 1'b0;
      check("midrst_dv",   {31'd0, dv8},   0);
      check("midrst_byte", {24'd0, byte8}, 0);
      check("midrst_act",  {31'd0, act8},  0);
      check("midrst_ferr", {31'd0, ferr8}, 0);
      drive(1'b0, 1'b1);
      repeat (40) @(negedge i_Clock);
      check("midrst_no_ferr", ferr_cnt8, ferr_before);
      q8.push_back(8'h81);
      send_frame(1'b0, 8'h81, 8, 1'b1, t0);
      wait_drain(1'b0, 50);

      // Skewed bit periods (+/-4%) at 100 clocks per bit
      for (int i = 0; i < 16; i++) begin
         b = 8'($urandom_range(0, 255));
         q100.push_back(b);
         send_frame(1'b1, b, 96 + 4 * int'($urandom_range(0, 2)), 1'b1, t0);
      end
      wait_drain(1'b1, 2000);
      check("skew_count", rx_cnt100, 16);
      check("skew_ferr", ferr_cnt100, 0);

      repeat (10) @(negedge i_Clock);
      check("final_q8", q8.size(), 0);
      check("never_3c", seen3c, 0);
      check("byte_only_on_dv", byte_glitch8, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver: recovers 8-bit bytes framed as 1 start bit, 8 data bits LSB-first, no parity, 1 stop bit, from an asynchronous line. It pairs with the team's UART transmitter and sits at the MMIO UART port, handing received bytes to the bus-side register logic. Each byte is delivered as a one-cycle valid strobe. Framing errors and start-bit glitches are detected and handled.

## Interface
- CLKS_PER_BIT, 16'd100, clock cycles per bit = f(i_Clock)/baud; legal range 4..65535.
- i_Clock  input  1  system clock, all logic on rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Rx_Serial  input  1  asynchronous serial line, idle high.
- o_Rx_DV  output  1  one-cycle pulse: o_Rx_Byte holds a newly received valid byte.
- o_Rx_Byte  output  8  last good byte; changes only when o_Rx_DV is asserted.
- o_Rx_Active  output  1  high while a frame is in progress (START, DATA, STOP).
- o_Frame_Err  output  1  one-cycle pulse: stop bit was sampled low.

## Operation
- i_Rx_Serial passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value (rx_s).
- HALF = (CLKS_PER_BIT-1)>>1. Bit counter is 16 bits; bit index is 3 bits.
- IDLE: counter=0, index=0. rx_s==0 -> START.
- START: counter increments. When counter==HALF: if rx_s==0, counter=0 and go to DATA; else go to IDLE (glitch rejected, no strobe).
- DATA: counter increments. At counter==CLKS_PER_BIT-1: shift rx_s into byte[index] and clear counter. If index==7, go to STOP; else index+1.
- STOP: counter increments. At counter==CLKS_PER_BIT-1, sample rx_s:
  - 1: load o_Rx_Byte, pulse o_Rx_DV, go to IDLE. The remaining half stop bit is not waited out, so the next start edge is accepted immediately.
  - 0: pulse o_Frame_Err, leave o_Rx_Byte unchanged, go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. A held-low line or break condition does not retrigger reception.
- o_Rx_DV and o_Frame_Err are never high together. Each is high for exactly one cycle per frame.
- No backpressure. The consumer must take the byte within one frame time; o_Rx_Byte is overwritten by the next good frame.
- Undefined state encodings go to IDLE.

## Timing
- Reset values: o_Rx_DV=0, o_Rx_Byte=8'h00, o_Rx_Active=0, o_Frame_Err=0, state=IDLE, counters=0, synchronizer=1.
- Reset asserted mid-frame aborts the frame in the next cycle with no strobe. Reception restarts only on a fresh falling edge after reset is released.
- Let t0 be the clock edge at which the first synchronizer flop captures the low start level.
  - IDLE->START transition happens at edge t0+2.
  - Data bit k is sampled at edge t0+3+HALF+(k+1)*CLKS_PER_BIT.
  - o_Rx_DV (or o_Frame_Err) rises at edge t0+3+HALF+9*CLKS_PER_BIT and falls one edge later.
- o_Rx_Active rises at edge t0+2 and falls together with the o_Rx_DV / o_Frame_Err rise.
- A start pulse must stay low through edge t0+3+HALF to be accepted.

## Structure
- Package uart_pkg holds:
  - 3-bit state constants: IDLE=0, START=1, DATA=2, STOP=3, BREAK=4.
  - Frame constants shared with the transmitter: DATA_BITS=8, counter width 16.
- Sub-module uart_rx_sync: 2-flop synchronizer with synchronous reset to 1, instantiated once for i_Rx_Serial.

## Test plan
- CLKS_PER_BIT=8, send 0xA5 (ideal timing) -> o_Rx_DV high for one cycle at t0+78, o_Rx_Byte=8'hA5, o_Frame_Err stays 0.
- Back-to-back 0x00 then 0xFF with exactly one stop bit each -> two o_Rx_DV pulses 80 cycles apart carrying 0x00 then 0xFF.
- Line low for 2 cycles, then high -> o_Rx_Active pulses briefly, no o_Rx_DV, no o_Frame_Err, o_Rx_Byte unchanged.
- Frame 0x3C with stop bit driven 0, line held low for 40 cycles, then valid 0x12 -> single o_Frame_Err pulse, no retrigger while the line is low, then o_Rx_DV with 0x12; o_Rx_Byte never shows 0x3C.
- i_Reset pulsed for 1 cycle during data bit 4 of 0x77 -> all outputs at reset values next cycle, no strobe for the aborted frame; a following 0x81 is received correctly.
- CLKS_PER_BIT=100, bit period skewed ±4% -> every byte of a 16-byte random sequence received correctly.
